multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter M_EXT, default 0; 1 enables RV32M decode (funct7=0000001 on opcode 0110011).
REQ-002 Parameter MUL_LAT, default 3; EXEC-state dwell in cycles for M-ext ops, legal range 1..15.
REQ-003 Parameter BUS_TIMEOUT, default 15; maximum cycles a memory request may wait for its ack, legal range 1..255.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 imem_req  out  1 / imem_ack  in  1 / imem_rdata  in  32  instruction fetch handshake and data.
REQ-008 dmem_req  out  1 / dmem_ack  in  1  data-memory handshake.
REQ-009 pc_w, ir_w, reg_w, mem_w, mem_to_reg, alu_src_a  out  1 each  datapath strobes and selects.
REQ-010 alu_src_b  out  2 (00 rs2, 01 imm, 10 const 4); ext_op  out  3 (I 000, U 001, S 010, B 011, J 100).
REQ-011 alu_ctr  out  5; branch  out  3 (000 none, 001 jal, 010 jalr, 011 cond); br_cond  out  3; mem_op  out  3.
REQ-012 state  out  3 current FSM state; illegal  out  1 sticky; bus_err  out  1 sticky.

Function
REQ-013 FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. IDLE always goes to FETCH on the next cycle.
REQ-014 FETCH: imem_req=1 until imem_ack. In the ack cycle: ir_w=1 for one cycle, imem_rdata captured in the internal IR, then DECODE.
REQ-015 DECODE (1 cycle): the control word is decoded from the IR and registered; the outputs of REQ-016..REQ-019 hold from EXEC until the next DECODE.
REQ-016 alu_ctr encodings:
- add 00000, sub 01000, sll 00001, slt 00010, sltu 01010, xor 00100, srl 00101, sra 01101, or 00110, and 00111, lui-pass 00011.
- M-ext ops: {2'b10, funct3}.
REQ-017 I-type ALU: alu_src_b=01; sltiu maps to 01010; srli/srai use funct7[5] as bit 3. R-type: bit 3 = funct7[5] only for funct3 000 and 101.
REQ-018 lui: ext 001, src_b 01, alu 00011. auipc: ext 001, src_a 1, src_b 01, add. jal: ext 100, branch 001, src_a 1, src_b 10. jalr: branch 010, src_a 1, src_b 10.
REQ-019 Loads/stores: ext 000/010, src_b 01, add, mem_op=funct3. B-type: ext 011, branch 011, br_cond=funct3, alu sub.
REQ-020 EXEC dwell: 1 cycle; MUL_LAT cycles for M-ext ops.
REQ-021 Transitions out of EXEC:
- loads and stores -> MEM.
- B-type -> FETCH with pc_w=1 in its last EXEC cycle.
- all other instructions -> WB.
REQ-022 MEM: dmem_req=1 until dmem_ack; mem_w=1 with dmem_req for stores only. Ack: store -> FETCH with pc_w=1; load -> WB with mem_to_reg=1.
REQ-023 WB (1 cycle): reg_w=1 and pc_w=1, then FETCH. reg_w is never asserted outside WB; pc_w is asserted exactly once per instruction.
REQ-024 Illegal instruction (unknown opcode, or funct7=0000001 with M_EXT=0): DECODE -> TRAP; illegal=1.
REQ-025 Request timeout: a request unacked after BUS_TIMEOUT cycles -> TRAP; bus_err=1; request dropped.
REQ-026 TRAP: all strobes and requests are 0; the FSM holds in TRAP until reset.
REQ-027 Acks are ignored when the matching request is 0. An ack in the same cycle as the request completes the transfer (zero-wait).

Reset
REQ-028 While rst=1: state=IDLE; IR=0; all outputs 0, including imem_req, illegal and bus_err.
REQ-029 rst asserted mid-transfer drops the request asynchronously; a late ack after reset is ignored.

Structure
REQ-030 Shared package holds: FSM state encodings, alu_ctr/ext_op/branch/alu_src_b encodings, and opcode constants.
REQ-031 Sub-module ctrl_decode holds the combinational decode of IR to control word plus illegal flag; the FSM, counters and registers stay in multicycle_ctrl.

Verification
REQ-032 addi 0x00500093, zero-wait acks -> IDLE,FETCH,DECODE,EXEC,WB; reg_w at cycle 5 after reset release; alu_ctr=00000, src_b=01.
REQ-033 lw 0x00002103, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles; mem_op=010; WB with mem_to_reg=1.
REQ-034 sw 0x00202023 -> mem_w=1 with dmem_req; no WB; pc_w in the ack cycle. beq 0x00000463 -> branch=011, br_cond=000, no reg_w.
REQ-035 mul 0x022081B3: M_EXT=1, MUL_LAT=3 -> EXEC 3 cycles, alu_ctr=10000. M_EXT=0 -> TRAP, illegal=1.
REQ-036 imem_ack withheld -> TRAP after 15 cycles with bus_err=1. Fetching 0x00000000 -> TRAP with illegal=1. rst mid-FETCH -> IDLE, all outputs 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, control-word
// field encodings, opcodes and the decoded control word itself.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        EXT_I = 3'b000,
        EXT_U = 3'b001,
        EXT_S = 3'b010,
        EXT_B = 3'b011,
        EXT_J = 3'b100
    } ext_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_COND = 3'b011
    } branch_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_e;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SLTU = 5'b01010;
    localparam logic [4:0] ALU_LUI  = 5'b00011;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // Everything DECODE registers for the rest of the instruction.
    typedef struct packed {
        logic       src_a;
        src_b_e     src_b;
        ext_e       ext;
        logic [4:0] alu;
        branch_e    br;
        logic [2:0] br_cond;
        logic [2:0] mem_op;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_mext;
    } ctrl_word_t;

    // Base-ISA ALU code; sltu/sltiu have their own code because funct3=011
    // would otherwise collide with the lui-pass slot.
    function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
        if (funct3 == 3'b011) return ALU_SLTU;
        return {1'b0, alt, funct3};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of the instruction register into a control word and
// an illegal-instruction flag.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int M_EXT = 0
) (
    input  logic [31:0] ir_i,
    output ctrl_word_t  cw_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = ir_i[6:0];
    assign funct3 = ir_i[14:12];
    assign funct7 = ir_i[31:25];
    // Register specifiers are routed by the datapath, not the controller.
    assign unused_fields = ^{ir_i[24:15], ir_i[11:7]};

    // Map opcode/funct fields to datapath selects and ALU operation.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        cw_o      = '0;
        illegal_o = 1'b0;
        case (opcode)
            OPC_OP: begin
                cw_o.src_b = SRC_B_RS2;
                if (funct7 == F7_MEXT) begin
                    if (M_EXT != 0) begin
                        cw_o.alu     = {2'b10, funct3};
                        cw_o.is_mext = 1'b1;
                    end else begin
                        illegal_o = 1'b1;
                    end
                end else begin
                    cw_o.alu = alu_base(funct3,
                        ((funct3 == 3'b000) || (funct3 == 3'b101)) && funct7[5]);
                end
            end
            OPC_OP_IMM: begin
                cw_o.ext   = EXT_I;
                cw_o.src_b = SRC_B_IMM;
                cw_o.alu   = alu_base(funct3, (funct3 == 3'b101) && funct7[5]);
            end
            OPC_LUI: begin
                cw_o.ext   = EXT_U;
                cw_o.src_b = SRC_B_IMM;
                cw_o.alu   = ALU_LUI;
            end
            OPC_AUIPC: begin
                cw_o.ext   = EXT_U;
                cw_o.src_a = 1'b1;
                cw_o.src_b = SRC_B_IMM;
                cw_o.alu   = ALU_ADD;
            end
            OPC_JAL: begin
                cw_o.ext   = EXT_J;
                cw_o.br    = BR_JAL;
                cw_o.src_a = 1'b1;
                cw_o.src_b = SRC_B_FOUR;
                cw_o.alu   = ALU_ADD;
            end
            OPC_JALR: begin
                cw_o.ext   = EXT_I;
                cw_o.br    = BR_JALR;
                cw_o.src_a = 1'b1;
                cw_o.src_b = SRC_B_FOUR;
                cw_o.alu   = ALU_ADD;
            end
            OPC_LOAD: begin
                cw_o.ext     = EXT_I;
                cw_o.src_b   = SRC_B_IMM;
                cw_o.alu     = ALU_ADD;
                cw_o.mem_op  = funct3;
                cw_o.is_load = 1'b1;
            end
            OPC_STORE: begin
                cw_o.ext      = EXT_S;
                cw_o.src_b    = SRC_B_IMM;
                cw_o.alu      = ALU_ADD;
                cw_o.mem_op   = funct3;
                cw_o.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                cw_o.ext       = EXT_B;
                cw_o.br        = BR_COND;
                cw_o.br_cond   = funct3;
                cw_o.src_b     = SRC_B_RS2;
                cw_o.alu       = ALU_SUB;
                cw_o.is_branch = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback with
// bus timeouts and a sticky trap state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int M_EXT       = 0,
    parameter int MUL_LAT     = 3,
    parameter int BUS_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        pc_w,
    output logic        ir_w,
    output logic        reg_w,
    output logic        mem_w,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  ext_op,
    output logic [4:0]  alu_ctr,
    output logic [2:0]  branch,
    output logic [2:0]  br_cond,
    output logic [2:0]  mem_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    localparam logic [7:0] TO_LAST  = 8'(BUS_TIMEOUT - 1);
    localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [31:0] ir_q;
    ctrl_word_t cw_q, dec_cw;
    logic       dec_illegal;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;

    ctrl_decode #(
        .M_EXT(M_EXT)
    ) u_decode (
        .ir_i      (ir_q),
        .cw_o      (dec_cw),
        .illegal_o (dec_illegal)
    );

    // State, counter, IR, registered control word and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: IR is a single register, not a memory, and must read 0 in reset, so it is reset here.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ir_q      <= '0;
            cw_q      <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            if (ir_w) ir_q <= imem_rdata;
            if (state_q == ST_DECODE) cw_q <= dec_cw;
        end
    end

    // Next-state logic, per-state strobes and handshake requests.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_w    = 1'b1;
                    state_d = ST_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cw_q.is_mext && (cnt_q != MUL_LAST)) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (cw_q.is_load || cw_q.is_store) begin
                    state_d = ST_MEM;
                end else if (cw_q.is_branch) begin
                    pc_w    = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                mem_w    = cw_q.is_store;
                if (dmem_ack) begin
                    if (cw_q.is_store) begin
                        pc_w    = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (cnt_q == TO_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WB: begin
                reg_w      = 1'b1;
                pc_w       = 1'b1;
                mem_to_reg = cw_q.is_load;
                state_d    = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign bus_err   = bus_err_q;
    assign alu_src_a = cw_q.src_a;
    assign alu_src_b = cw_q.src_b;
    assign ext_op    = cw_q.ext;
    assign alu_ctr   = cw_q.alu;
    assign branch    = cw_q.br;
    assign br_cond   = cw_q.br_cond;
    assign mem_op    = cw_q.mem_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one default instance (M_EXT=0) and one
// M-extension instance (M_EXT=1) driven by the same stimulus.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    logic        clk, rst, imem_ack, dmem_ack;
    logic [31:0] imem_rdata;

    logic imem_req, dmem_req, pc_w, ir_w, reg_w, mem_w, mem_to_reg, alu_src_a, illegal, bus_err;
    logic [1:0] alu_src_b;
    logic [2:0] ext_op, branch, br_cond, mem_op, state;
    logic [4:0] alu_ctr;

    logic m_imem_req, m_dmem_req, m_pc_w, m_ir_w, m_reg_w, m_mem_w, m_mem_to_reg, m_alu_src_a, m_illegal, m_bus_err;
    logic [1:0] m_alu_src_b;
    logic [2:0] m_ext_op, m_branch, m_br_cond, m_mem_op, m_state;
    logic [4:0] m_alu_ctr;

    logic [31:0] outs0;
    assign outs0 = {imem_req, dmem_req, pc_w, ir_w, reg_w, mem_w, mem_to_reg, alu_src_a,
                    alu_src_b, ext_op, alu_ctr, branch, br_cond, mem_op, state, illegal, bus_err};

    int checks_n = 0;
    int errors_n = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_w(pc_w), .ir_w(ir_w), .reg_w(reg_w),
        .mem_w(mem_w), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .alu_ctr(alu_ctr), .branch(branch), .br_cond(br_cond), .mem_op(mem_op),
        .state(state), .illegal(illegal), .bus_err(bus_err)
    );

    multicycle_ctrl #(.M_EXT(1), .MUL_LAT(3), .BUS_TIMEOUT(15)) dut_m (
        .clk(clk), .rst(rst), .imem_req(m_imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(m_dmem_req), .dmem_ack(dmem_ack), .pc_w(m_pc_w), .ir_w(m_ir_w), .reg_w(m_reg_w),
        .mem_w(m_mem_w), .mem_to_reg(m_mem_to_reg), .alu_src_a(m_alu_src_a), .alu_src_b(m_alu_src_b),
        .ext_op(m_ext_op), .alu_ctr(m_alu_ctr), .branch(m_branch), .br_cond(m_br_cond), .mem_op(m_mem_op),
        .state(m_state), .illegal(m_illegal), .bus_err(m_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset two cycles, check outputs, release; caller is then in cycle 1 (IDLE).
    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        step();
        step();
        check("reset_outs", outs0, 32'h0);
        check("reset_m_state", {29'd0, m_state}, {29'd0, S_IDLE});
        rst = 1'b0;
        #1;
    endtask

    // Zero-wait fetch starting in FETCH; ends in DECODE.
    task automatic fetch_zw(input logic [31:0] instr);
        check("fetch_state", {29'd0, state}, {29'd0, S_FETCH});
        imem_rdata = instr; imem_ack = 1'b1;
        #1;
        check("fetch_ir_w", {31'd0, ir_w}, 32'd1);
        step();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("decode_state", {29'd0, state}, {29'd0, S_DECODE});
        check("decode_ir_w", {31'd0, ir_w}, 32'd0);
    endtask

    initial begin
        int n;
        do_reset();

        // addi: IDLE,FETCH,DECODE,EXEC,WB with reg_w in cycle 5
        check("addi_c1_idle", {29'd0, state}, {29'd0, S_IDLE});
        step();
        check("addi_c2_req", {31'd0, imem_req}, 32'd1);
        fetch_zw(32'h0050_0093);
        step();
        check("addi_exec", {29'd0, state}, {29'd0, S_EXEC});
        check("addi_alu", {27'd0, alu_ctr}, 32'h00);
        check("addi_srcb", {30'd0, alu_src_b}, 32'd1);
        check("addi_exec_regw", {30'd0, reg_w, pc_w}, 32'd0);
        step();
        check("addi_c5_wb", {29'd0, state}, {29'd0, S_WB});
        check("addi_wb_strobes", {29'd0, reg_w, pc_w, mem_to_reg}, 32'b110);
        step();

        // lw with dmem_ack delayed 3 cycles
        fetch_zw(32'h0000_2103);
        step();
        check("lw_memop", {29'd0, mem_op}, 32'd2);
        check("lw_ext_srcb", {27'd0, ext_op, alu_src_b}, {27'd0, 3'b000, 2'b01});
        step();
        check("lw_mem_state", {29'd0, state}, {29'd0, S_MEM});
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_ack = 1'b1;
            #1;
            if (dmem_req) n++;
            if (i == 3) check("lw_ack_no_pcw", {30'd0, pc_w, mem_w}, 32'd0);
            step();
        end
        dmem_ack = 1'b0;
        #1;
        check("lw_req_cycles", n, 4);
        check("lw_wb_state", {29'd0, state}, {29'd0, S_WB});
        check("lw_wb_strobes", {28'd0, reg_w, pc_w, mem_to_reg, dmem_req}, 32'b1110);
        step();

        // sw, zero-wait dmem
        fetch_zw(32'h0020_2023);
        step();
        check("sw_ext_memop", {26'd0, ext_op, mem_op}, {26'd0, 3'b010, 3'b010});
        step();
        check("sw_mem_w", {30'd0, dmem_req, mem_w}, 32'b11);
        dmem_ack = 1'b1;
        #1;
        check("sw_ack_pcw", {30'd0, pc_w, reg_w}, 32'b10);
        step();
        dmem_ack = 1'b0;
        #1;
        check("sw_no_wb", {29'd0, state}, {29'd0, S_FETCH});

        // beq
        fetch_zw(32'h0000_0463);
        step();
        check("beq_branch", {29'd0, branch}, 32'd3);
        check("beq_cond_alu", {24'd0, br_cond, alu_ctr}, {24'd0, 3'b000, 5'b01000});
        check("beq_ext", {29'd0, ext_op}, 32'd3);
        check("beq_pcw_regw", {30'd0, pc_w, reg_w}, 32'b10);
        step();
        check("beq_to_fetch", {29'd0, state}, {29'd0, S_FETCH});

        // sub (R-type, funct7[5] selects subtract)
        fetch_zw(32'h4020_81B3);
        step();
        check("sub_alu_srcb", {25'd0, alu_ctr, alu_src_b}, {25'd0, 5'b01000, 2'b00});
        step();
        check("sub_wb", {29'd0, state}, {29'd0, S_WB});
        step();

        // srai (I-type, funct7[5] selects arithmetic shift)
        fetch_zw(32'h4010_D093);
        step();
        check("srai_alu", {27'd0, alu_ctr}, 32'b01101);
        step();
        step();

        // jal
        fetch_zw(32'h0080_006F);
        step();
        check("jal_ctl", {24'd0, ext_op, branch, alu_src_a, alu_src_b[0]},
              {24'd0, 3'b100, 3'b001, 1'b1, 1'b0});
        check("jal_srcb", {30'd0, alu_src_b}, 32'd2);
        step();
        check("jal_wb", {29'd0, state, reg_w}, {28'd0, S_WB, 1'b1});
        step();

        // mul: M_EXT=1 dwells 3 cycles in EXEC, M_EXT=0 traps as illegal
        fetch_zw(32'h0220_81B3);
        step();
        check("mul_m0_trap", {29'd0, state}, {29'd0, S_TRAP});
        check("mul_m0_illegal", {30'd0, illegal, bus_err}, 32'b10);
        n = 0;
        for (int i = 0; i < 10 && m_state == S_EXEC; i++) begin
            n++;
            if (i == 0) check("mul_alu", {27'd0, m_alu_ctr}, 32'b10000);
            if (m_pc_w || m_reg_w) check("mul_exec_strobe", {30'd0, m_pc_w, m_reg_w}, 32'd0);
            step();
        end
        check("mul_exec_cycles", n, 3);
        check("mul_m1_wb", {28'd0, m_state, m_reg_w}, {28'd0, S_WB, 1'b1});
        imem_ack = 1'b1;
        step();
        step();
        imem_ack = 1'b0;
        check("trap_hold", {29'd0, state}, {29'd0, S_TRAP});
        check("trap_strobes", {25'd0, imem_req, dmem_req, pc_w, ir_w, reg_w, mem_w, mem_to_reg}, 32'd0);

        // fetch of all-zero word traps as illegal
        do_reset();
        step();
        fetch_zw(32'h0000_0000);
        step();
        check("zero_trap", {29'd0, state}, {29'd0, S_TRAP});
        check("zero_illegal", {30'd0, illegal, bus_err}, 32'b10);

        // imem_ack withheld: 15 request cycles then TRAP with bus_err
        do_reset();
        step();
        n = 0;
        for (int i = 0; i < 40 && state != S_TRAP; i++) begin
            if (imem_req) n++;
            step();
        end
        check("to_req_cycles", n, 15);
        check("to_state", {29'd0, state}, {29'd0, S_TRAP});
        check("to_flags", {29'd0, bus_err, illegal, imem_req}, 32'b100);
        imem_ack = 1'b1;
        step();
        check("to_late_ack", {29'd0, state, ir_w}, {28'd0, S_TRAP, 1'b0});
        imem_ack = 1'b0;

        // reset asserted mid-FETCH drops the request asynchronously
        do_reset();
        step();
        fetch_zw(32'h0050_0093);
        step();
        step();
        step();
        check("rst_pre_fetch", {30'd0, state == S_FETCH, imem_req}, 32'b11);
        rst = 1'b1;
        #1;
        check("rst_async_outs", outs0, 32'h0);
        imem_ack = 1'b1;
        step();
        check("rst_hold_outs", outs0, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_late_ack", {29'd0, state, ir_w}, {28'd0, S_IDLE, 1'b0});
        step();
        imem_ack = 1'b0;
        #1;
        check("rst_refetch", {29'd0, state, imem_req}, {28'd0, S_FETCH, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks_n, errors_n);
        $finish;
    end

endmodule
